// File: rtl/gpr_pkg.sv
// Shared constants and types for the gpr_file register file and its scoreboard.
package gpr_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  typedef logic [GPR_ADDR_W-1:0] reg_idx_t;
  typedef logic [GPR_DATA_W-1:0] reg_data_t;

endpackage : gpr_pkg

// File: rtl/gpr_scoreboard.sv
// Write-pending scoreboard: one busy flag per register, a registered popcount
// of those flags, and a sticky error for writes to registers not reserved.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_idx_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  output logic [NREGS-1:0]  busy_o,
  output logic [ADDR_W:0]   busy_count_o,
  output logic              write_err_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             err_q, err_d;

  // Next-state: the write clears first so a same-cycle issue re-reserves.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_idx_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid_i && (issue_idx_i != {ADDR_W{1'b0}})) begin
      busy_d[issue_idx_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;

    count_d = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end

    if (wr_en_i && (wr_idx_i != {ADDR_W{1'b0}}) && !busy_q[wr_idx_i]) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= {NREGS{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;
  assign write_err_o  = err_q;

endmodule : gpr_scoreboard

// File: rtl/gpr_file.sv
// Parametrised GPR file with NUM_RD combinational read ports and write-pending scoreboard.
// Define GPR_BYPASS_EN to compile in same-cycle write-to-read forwarding.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegisterSelect,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueReg,
  input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
  output logic [NUM_RD*DATA_W-1:0] DataOut,
  output logic [NUM_RD-1:0]        Busy,
  output logic [ADDR_W:0]          BusyCount,
  output logic                     WriteErr
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  busy_s;

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk_i         (CLK),
    .rst_i         (RST),
    .issue_valid_i (IssueValid),
    .issue_idx_i   (IssueReg),
    .wr_en_i       (RegWrite),
    .wr_idx_i      (WriteRegisterSelect),
    .busy_o        (busy_s),
    .busy_count_o  (BusyCount),
    .write_err_o   (WriteErr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (RegWrite && (WriteRegisterSelect != {ADDR_W{1'b0}})) begin
      mem_q[WriteRegisterSelect] <= WriteData;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Read muxes; r0 is forced to zero regardless of array contents.
  always_comb begin
    logic [ADDR_W-1:0] idx_s;
    DataOut = {(NUM_RD*DATA_W){1'b0}};
    Busy    = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      idx_s = ReadRegister[k*ADDR_W +: ADDR_W];
      if (idx_s == {ADDR_W{1'b0}}) begin
        DataOut[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        Busy[k]                     = 1'b0;
      end else begin
        DataOut[k*DATA_W +: DATA_W] = mem_q[idx_s];
        Busy[k]                     = busy_s[idx_s];
`ifdef GPR_BYPASS_EN
        if (RegWrite && (idx_s == WriteRegisterSelect)) begin
          DataOut[k*DATA_W +: DATA_W] = WriteData;
          Busy[k]                     = IssueValid && (IssueReg == idx_s);
        end else begin
          Busy[k] = Busy[k];
        end
`endif
      end
    end
  end

endmodule : gpr_file
